window5_ctrl: RTL and testbench

Sequencing controller for the 5-row line-buffer chain in the convolution front end. Accepts a raster-scan pixel stream of one ROWS×COLS frame under a valid/ready handshake and drives the shared `en` of the 5-row buffer. Tracks row and column position and flags each cycle in which the buffer taps plus the downstream column shift registers hold a complete 5×5 window at a stride-aligned position. Applies backpressure so that no window is lost while the consumer stalls.

---
 rtl/window5_ctrl_pkg.sv | 21 ++
 rtl/window5_ctrl_if.sv | 30 +++
 rtl/window5_ctrl_raster_counter.sv | 96 +++++++++
 rtl/window5_ctrl.sv | 117 +++++++++++
 tb/tb_window5_ctrl.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/window5_ctrl_pkg.sv
// Shared conv-front-end definitions: controller state encoding, the
// window size, and an index-width helper used to size the output-map
// row/column indices.
package window5_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int WIN = 5;

  // Width needed to hold values 0..n-1. Never returns 0, so a degenerate
  // one-entry range still gets a usable 1-bit signal.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/window5_ctrl_if.sv
// Handshake bundle between the window controller and its environment.
//   start, in_valid, out_ready        : driven by the environment (master)
//   in_ready, rb_en                   : pixel-side handshake / row-buffer enable
//   win_valid, win_row, win_col       : window flag and output-map indices
//   busy, frame_done                  : frame status
interface window5_ctrl_if #(
  parameter int ROW_W = 3,
  parameter int COL_W = 3
);
  logic             start;
  logic             in_valid;
  logic             in_ready;
  logic             rb_en;
  logic             out_ready;
  logic             win_valid;
  logic [ROW_W-1:0] win_row;
  logic [COL_W-1:0] win_col;
  logic             busy;
  logic             frame_done;

  modport master (
    output start, in_valid, out_ready,
    input  in_ready, rb_en, win_valid, win_row, win_col, busy, frame_done
  );

  modport slave (
    input  start, in_valid, out_ready,
    output in_ready, rb_en, win_valid, win_row, win_col, busy, frame_done
  );
endinterface

// File: rtl/window5_ctrl_raster_counter.sv
// Raster position tracker: column/row counters with wrap, plus per-axis
// stride phase and output-map index counters.
//   i_clr      : clear all counters (frame start)
//   i_adv      : one pixel accepted at the current position
//   o_last     : current position is the last pixel of the frame
//   o_hit      : accepting at the current position completes a window
//   o_row_idx  : output-map row index of the current position
//   o_col_idx  : output-map column index of the current position
module raster_counter
  import window5_ctrl_pkg::*;
#(
  parameter int COLS   = 10,
  parameter int ROWS   = 10,
  parameter int STRIDE = 1,
  parameter int ROW_W  = 3,
  parameter int COL_W  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_adv,
  output logic             o_last,
  output logic             o_hit,
  output logic [ROW_W-1:0] o_row_idx,
  output logic [COL_W-1:0] o_col_idx
);
  localparam int CW = idx_w(COLS);
  localparam int RW = idx_w(ROWS);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [CW-1:0] COL_ORG  = CW'(WIN - 1);
  localparam logic [CW-1:0] COL_PRE  = CW'(WIN - 2);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [RW-1:0] ROW_ORG  = RW'(WIN - 1);
  localparam logic [RW-1:0] ROW_PRE  = RW'(WIN - 2);
  localparam logic [1:0]    PH_LAST  = 2'(STRIDE - 1);

  logic [CW-1:0]    r_col;
  logic [RW-1:0]    r_row;
  logic [1:0]       r_col_ph;
  logic [1:0]       r_row_ph;
  logic [COL_W-1:0] r_col_idx;
  logic [ROW_W-1:0] r_row_idx;
  logic             w_col_wrap;

  assign w_col_wrap = (r_col == COL_LAST);
  assign o_last     = w_col_wrap && (r_row == ROW_LAST);
  // Phases hold (pos-4)%STRIDE for the current position; they are only
  // meaningful once the position reaches the window origin.
  assign o_hit      = (r_row >= ROW_ORG) && (r_col >= COL_ORG) &&
                      (r_row_ph == 2'd0) && (r_col_ph == 2'd0);
  assign o_row_idx  = r_row_idx;
  assign o_col_idx  = r_col_idx;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_col     <= '0;
      r_row     <= '0;
      r_col_ph  <= '0;
      r_row_ph  <= '0;
      r_col_idx <= '0;
      r_row_idx <= '0;
    end else if (i_adv) begin
      if (w_col_wrap) begin
        r_col     <= '0;
        r_col_ph  <= '0;
        r_col_idx <= '0;
        r_row     <= (r_row == ROW_LAST) ? '0 : r_row + RW'(1);
        if (r_row == ROW_PRE) begin
          r_row_ph  <= '0;
          r_row_idx <= '0;
        end else if (r_row >= ROW_ORG) begin
          if (r_row_ph == PH_LAST) begin
            r_row_ph  <= '0;
            r_row_idx <= r_row_idx + ROW_W'(1);
          end else begin
            r_row_ph <= r_row_ph + 2'd1;
          end
        end
      end else begin
        r_col <= r_col + CW'(1);
        if (r_col == COL_PRE) begin
          r_col_ph  <= '0;
          r_col_idx <= '0;
        end else if (r_col >= COL_ORG) begin
          if (r_col_ph == PH_LAST) begin
            r_col_ph  <= '0;
            r_col_idx <= r_col_idx + COL_W'(1);
          end else begin
            r_col_ph <= r_col_ph + 2'd1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/window5_ctrl.sv
// Sequencing controller for the 5-row line-buffer chain. Accepts one
// ROWSxCOLS raster frame, drives the row-buffer enable, and flags each
// stride-aligned complete 5x5 window, holding off input while a window
// is waiting for the consumer.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of window5_ctrl_if (see interface for signals)
//
// state  | meaning
// IDLE   | waiting for start
// STREAM | accepting pixels, flagging windows
// DRAIN  | all pixels taken, waiting for the last window to be consumed
// DONE   | frame_done pulse, back to IDLE
module window5_ctrl
  import window5_ctrl_pkg::*;
#(
  parameter int COLS   = 10,
  parameter int ROWS   = 10,
  parameter int STRIDE = 1
) (
  input  logic           clk,
  input  logic           rst,
  window5_ctrl_if.slave  bus
);
  localparam int ROW_W = idx_w((ROWS - WIN) / STRIDE + 1);
  localparam int COL_W = idx_w((COLS - WIN) / STRIDE + 1);

  state_t           r_state;
  logic             r_win_valid;
  logic [ROW_W-1:0] r_win_row;
  logic [COL_W-1:0] r_win_col;
  logic             r_busy;
  logic             r_frame_done;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_hs;
  logic             w_clr;
  logic             w_last;
  logic             w_hit;
  logic [ROW_W-1:0] w_hit_row;
  logic [COL_W-1:0] w_hit_col;

  // Never shift the buffer while an unconsumed window sits at the taps.
  assign w_in_ready = (r_state == STREAM) && (!r_win_valid || bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_hs       = r_win_valid && bus.out_ready;
  assign w_clr      = (r_state == IDLE) && bus.start;

  raster_counter #(
    .COLS   (COLS),
    .ROWS   (ROWS),
    .STRIDE (STRIDE),
    .ROW_W  (ROW_W),
    .COL_W  (COL_W)
  ) u_raster (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_clr),
    .i_adv     (w_accept),
    .o_last    (w_last),
    .o_hit     (w_hit),
    .o_row_idx (w_hit_row),
    .o_col_idx (w_hit_col)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_win_valid  <= 1'b0;
      r_win_row    <= '0;
      r_win_col    <= '0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      if (w_accept && w_hit) begin
        r_win_valid <= 1'b1;
        r_win_row   <= w_hit_row;
        r_win_col   <= w_hit_col;
      end else if (w_hs) begin
        r_win_valid <= 1'b0;
      end
      r_frame_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_state <= STREAM;
            r_busy  <= 1'b1;
          end
        end
        STREAM: begin
          if (w_accept && w_last) r_state <= DRAIN;
        end
        DRAIN: begin
          // Leave as soon as the window register is empty after this edge.
          if (!r_win_valid || bus.out_ready) begin
            r_state      <= DONE;
            r_frame_done <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.rb_en      = w_accept;
  assign bus.win_valid  = r_win_valid;
  assign bus.win_row    = r_win_row;
  assign bus.win_col    = r_win_col;
  assign bus.busy       = r_busy;
  assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_window5_ctrl.sv
// Bench for window5_ctrl: a STRIDE=1 and a STRIDE=2 instance on a 10x10
// frame, driven from the same stimulus.
module tb_window5_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;

  always #5 clk = ~clk;

  window5_ctrl_if #(.ROW_W(3), .COL_W(3)) if1 ();
  window5_ctrl_if #(.ROW_W(2), .COL_W(2)) if2 ();

  assign if1.start = start;
  assign if1.in_valid = in_valid;
  assign if1.out_ready = out_ready;
  assign if2.start = start;
  assign if2.in_valid = in_valid;
  assign if2.out_ready = out_ready;

  window5_ctrl #(.COLS(10), .ROWS(10), .STRIDE(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1.slave)
  );

  window5_ctrl #(.COLS(10), .ROWS(10), .STRIDE(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (if2.slave)
  );

  int errors = 0;
  int checks = 0;

  int n1, n2, acc1, acc2, fd1, fd2, first1, first2;
  int last_cyc1, last_cyc2, fd_cyc1, fd_cyc2;
  int stall_seen, stall_bad, bad;
  bit aborted;
  int wr1[64], wc1[64], wr2[64], wc2[64];

  // Runs one frame cycle by cycle: inputs change at the falling edge,
  // outputs are sampled 1 time unit later, and consumed windows, accepts
  // and frame_done pulses are logged for the calling test to inspect.
  task automatic run_frame(input bit gaps, input int stall_win, input bit glitch, input int abort_at);
    int stall_left = 0;
    bit stall_done = 1'b0;
    bit glitched = 1'b0;
    logic [2:0] snap_r = '0;
    logic [2:0] snap_c = '0;
    n1 = 0; n2 = 0; acc1 = 0; acc2 = 0; fd1 = 0; fd2 = 0;
    first1 = -1; first2 = -1; last_cyc1 = -1; last_cyc2 = -1;
    fd_cyc1 = -1; fd_cyc2 = -1; stall_seen = 0; stall_bad = 0; aborted = 1'b0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      @(negedge clk);
      start = (cyc == 0);
      if (glitch && cyc == 30) start = 1'b1;
      if (glitch && !glitched && acc1 == 100) begin
        start = 1'b1;
        glitched = 1'b1;
      end
      in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stall_win >= 0 && !stall_done && stall_left == 0 && n1 == stall_win && if1.win_valid) begin
        stall_left = 5;
        snap_r = if1.win_row;
        snap_c = if1.win_col;
      end
      out_ready = (stall_left == 0);
      #1;
      if (stall_left > 0) begin
        stall_seen++;
        if (if1.in_ready || if1.rb_en || !if1.win_valid || if1.win_row != snap_r || if1.win_col != snap_c)
          stall_bad++;
        stall_left--;
        if (stall_left == 0) stall_done = 1'b1;
      end
      if (if1.win_valid && out_ready) begin
        if (n1 == 0) first1 = acc1;
        if (n1 < 64) begin
          wr1[n1] = int'(if1.win_row);
          wc1[n1] = int'(if1.win_col);
        end
        n1++;
      end
      if (if2.win_valid && out_ready) begin
        if (n2 == 0) first2 = acc2;
        if (n2 < 64) begin
          wr2[n2] = int'(if2.win_row);
          wc2[n2] = int'(if2.win_col);
        end
        n2++;
      end
      if (if1.rb_en) begin acc1++; last_cyc1 = cyc; end
      if (if2.rb_en) begin acc2++; last_cyc2 = cyc; end
      if (if1.frame_done) begin fd1++; fd_cyc1 = cyc; end
      if (if2.frame_done) begin fd2++; fd_cyc2 = cyc; end
      if (abort_at > 0 && acc1 >= abort_at) begin
        aborted = 1'b1;
        break;
      end
      if (fd_cyc1 >= 0 && fd_cyc2 >= 0 && cyc >= fd_cyc1 + 3 && cyc >= fd_cyc2 + 3) break;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({if1.in_ready, if1.rb_en, if1.win_valid, if1.busy, if1.frame_done, if1.win_row, if1.win_col} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs_s1: got %b want 0", {if1.in_ready, if1.rb_en, if1.win_valid, if1.busy, if1.frame_done, if1.win_row, if1.win_col});
    end
    checks++;
    if ({if2.in_ready, if2.rb_en, if2.win_valid, if2.busy, if2.frame_done, if2.win_row, if2.win_col} !== 9'd0) begin
      errors++;
      $display("FAIL reset_outputs_s2: got %b want 0", {if2.in_ready, if2.rb_en, if2.win_valid, if2.busy, if2.frame_done, if2.win_row, if2.win_col});
    end
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (if1.in_ready !== 1'b0 || if1.busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_start: got in_ready=%b busy=%b want 0 0", if1.in_ready, if1.busy);
    end
  endtask

  task automatic test_stride1();
    run_frame(1'b0, -1, 1'b0, 0);
    checks++;
    if (n1 != 36) begin errors++; $display("FAIL s1_count: got %0d want 36", n1); end
    bad = 0;
    for (int k = 0; k < n1 && k < 64; k++)
      if (wr1[k] != k / 6 || wc1[k] != k % 6) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL s1_order: got %0d misordered want 0", bad); end
    checks++;
    if (first1 != 45) begin errors++; $display("FAIL s1_first_latency: got %0d accepts want 45", first1); end
    checks++;
    if (acc1 != 100) begin errors++; $display("FAIL s1_accepts: got %0d want 100", acc1); end
    checks++;
    if (fd1 != 1) begin errors++; $display("FAIL s1_frame_done_count: got %0d want 1", fd1); end
    checks++;
    if (fd_cyc1 - last_cyc1 != 2) begin errors++; $display("FAIL s1_done_delay: got %0d want 2", fd_cyc1 - last_cyc1); end
    checks++;
    if (fd_cyc1 != 102) begin errors++; $display("FAIL s1_frame_time: got %0d want 102", fd_cyc1); end
    checks++;
    if (if1.busy !== 1'b0) begin errors++; $display("FAIL s1_busy_after: got %b want 0", if1.busy); end
  endtask

  task automatic test_stride2();
    run_frame(1'b0, -1, 1'b0, 0);
    checks++;
    if (n2 != 9) begin errors++; $display("FAIL s2_count: got %0d want 9", n2); end
    bad = 0;
    for (int k = 0; k < n2 && k < 64; k++)
      if (wr2[k] != k / 3 || wc2[k] != k % 3) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL s2_order: got %0d misordered want 0", bad); end
    checks++;
    if (first2 != 45) begin errors++; $display("FAIL s2_first_latency: got %0d accepts want 45", first2); end
    checks++;
    if (fd2 != 1 || fd_cyc2 - last_cyc2 != 2) begin
      errors++;
      $display("FAIL s2_done: got count=%0d delay=%0d want 1 2", fd2, fd_cyc2 - last_cyc2);
    end
  endtask

  task automatic test_backpressure();
    run_frame(1'b0, 10, 1'b0, 0);
    checks++;
    if (stall_seen != 5) begin errors++; $display("FAIL bp_stall_cycles: got %0d want 5", stall_seen); end
    checks++;
    if (stall_bad != 0) begin errors++; $display("FAIL bp_hold: got %0d bad cycles want 0", stall_bad); end
    bad = 0;
    for (int k = 0; k < n1 && k < 64; k++)
      if (wr1[k] != k / 6 || wc1[k] != k % 6) bad++;
    checks++;
    if (n1 != 36 || bad != 0) begin errors++; $display("FAIL bp_windows: got %0d (%0d misordered) want 36 (0)", n1, bad); end
    checks++;
    if (n2 != 9 || fd1 != 1) begin errors++; $display("FAIL bp_s2_done: got n2=%0d fd=%0d want 9 1", n2, fd1); end
  endtask

  task automatic test_gaps();
    run_frame(1'b1, -1, 1'b0, 0);
    checks++;
    if (acc1 != 100 || acc2 != 100) begin errors++; $display("FAIL gaps_accepts: got %0d/%0d want 100", acc1, acc2); end
    bad = 0;
    for (int k = 0; k < n1 && k < 64; k++)
      if (wr1[k] != k / 6 || wc1[k] != k % 6) bad++;
    for (int k = 0; k < n2 && k < 64; k++)
      if (wr2[k] != k / 3 || wc2[k] != k % 3) bad++;
    checks++;
    if (n1 != 36 || n2 != 9 || bad != 0) begin
      errors++;
      $display("FAIL gaps_windows: got %0d/%0d (%0d misordered) want 36/9 (0)", n1, n2, bad);
    end
    checks++;
    if (fd1 != 1 || fd2 != 1) begin errors++; $display("FAIL gaps_done: got %0d/%0d want 1/1", fd1, fd2); end
  endtask

  task automatic test_reset_midframe();
    run_frame(1'b0, -1, 1'b0, 57);
    checks++;
    if (!aborted || if1.busy !== 1'b1 || fd1 != 0) begin
      errors++;
      $display("FAIL mid_pre_reset: got aborted=%0d busy=%b fd=%0d want 1 1 0", aborted, if1.busy, fd1);
    end
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if ({if1.in_ready, if1.rb_en, if1.win_valid, if1.busy, if1.frame_done, if1.win_row, if1.win_col} !== 11'd0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got %b want 0", {if1.in_ready, if1.rb_en, if1.win_valid, if1.busy, if1.frame_done, if1.win_row, if1.win_col});
    end
    rst = 1'b0;
    run_frame(1'b0, -1, 1'b0, 0);
    bad = 0;
    for (int k = 0; k < n1 && k < 64; k++)
      if (wr1[k] != k / 6 || wc1[k] != k % 6) bad++;
    checks++;
    if (n1 != 36 || bad != 0 || first1 != 45) begin
      errors++;
      $display("FAIL mid_next_frame: got n=%0d bad=%0d first=%0d want 36 0 45", n1, bad, first1);
    end
  endtask

  task automatic test_start_ignored();
    run_frame(1'b0, -1, 1'b1, 0);
    checks++;
    if (fd1 != 1 || fd2 != 1) begin errors++; $display("FAIL glitch_done: got %0d/%0d want 1/1", fd1, fd2); end
    bad = 0;
    for (int k = 0; k < n1 && k < 64; k++)
      if (wr1[k] != k / 6 || wc1[k] != k % 6) bad++;
    checks++;
    if (n1 != 36 || bad != 0 || acc1 != 100) begin
      errors++;
      $display("FAIL glitch_windows: got n=%0d bad=%0d acc=%0d want 36 0 100", n1, bad, acc1);
    end
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (if1.busy !== 1'b0 || if2.busy !== 1'b0) begin
      errors++;
      $display("FAIL glitch_idle: got busy=%b%b want 00", if1.busy, if2.busy);
    end
  endtask

  initial begin
    test_reset();
    test_stride1();
    test_stride2();
    test_backpressure();
    test_gaps();
    test_reset_midframe();
    test_start_ignored();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
